// File: rtl/dct_pkg.sv
// Shared constants and data types for the 8-point DCT/IDCT column stages.
// Cosines are scaled by 2^COEF_FRAC; results are rounded by RND and shifted by SHIFT.
package dct_pkg;

    localparam int unsigned DCT_SIZE      = 8;
    localparam int unsigned DCT_SIZE_IN   = DCT_SIZE + 3;
    localparam int unsigned DCT_SIZE_MULT = DCT_SIZE_IN + 8;
    localparam int unsigned DCT_SIZE_ACC  = DCT_SIZE_IN + 11;

    localparam int unsigned C1 = 63;
    localparam int unsigned C2 = 59;
    localparam int unsigned C3 = 53;
    localparam int unsigned C4 = 45;
    localparam int unsigned C5 = 36;
    localparam int unsigned C6 = 24;
    localparam int unsigned C7 = 12;

    localparam int unsigned COEF_FRAC = 6;
    localparam int unsigned RND       = 64;
    localparam int unsigned SHIFT     = 7;

    typedef logic signed [DCT_SIZE_IN-1:0]   coef_t;
    typedef logic signed [DCT_SIZE_MULT-1:0] prod_t;
    typedef logic signed [DCT_SIZE_ACC-1:0]  acc_t;
    typedef logic signed [DCT_SIZE-1:0]      pix_t;

endpackage

// File: rtl/idct_round_sat.sv
// Rounds a full-precision accumulator by 2^SHIFT and clamps it to a signed SIZE-bit sample.
module idct_round_sat
    import dct_pkg::*;
#(
    parameter int unsigned SIZE     = DCT_SIZE,
    parameter int unsigned SIZE_ACC = DCT_SIZE_ACC
) (
    input  logic signed [SIZE_ACC-1:0] i_acc,
    output logic signed [SIZE-1:0]     o_pix
);

    localparam int unsigned SW = SIZE_ACC + 1;
    localparam int unsigned QW = SW - SHIFT;
    localparam logic signed [QW-1:0] PIX_MAX = QW'((1 << (SIZE - 1)) - 1);
    localparam logic signed [QW-1:0] PIX_MIN = ~PIX_MAX;

    logic signed [SW-1:0] w_sum;
    logic signed [QW-1:0] w_q;

    // One extra bit keeps the rounding add from wrapping at the positive extreme.
    always_comb begin
        w_sum = SW'(i_acc) + SW'(RND);
        w_q   = w_sum[SW-1:SHIFT];
        if (w_q > PIX_MAX) begin
            o_pix = PIX_MAX[SIZE-1:0];
        end else if (w_q < PIX_MIN) begin
            o_pix = PIX_MIN[SIZE-1:0];
        end else begin
            o_pix = w_q[SIZE-1:0];
        end
    end

endmodule

// File: rtl/idct_col.sv
// 1-D 8-point inverse DCT column stage: products, even/odd butterflies, round/saturate.
// Three register stages that all advance together whenever the output slot can move.
module idct_col
    import dct_pkg::*;
#(
    parameter int unsigned SIZE        = DCT_SIZE,
    parameter int unsigned SIZE_IN     = SIZE + 3,
    parameter int unsigned APPROX_BITS = 0,
    parameter int unsigned SIZE_MULT   = SIZE_IN + 8,
    parameter int unsigned SIZE_ACC    = SIZE_IN + 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*SIZE_IN-1:0]   data_in,
    input  logic                   approx_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*SIZE-1:0]      data_out
);

    localparam logic signed [SIZE_MULT-1:0] K1 = SIZE_MULT'(C1);
    localparam logic signed [SIZE_MULT-1:0] K2 = SIZE_MULT'(C2);
    localparam logic signed [SIZE_MULT-1:0] K3 = SIZE_MULT'(C3);
    localparam logic signed [SIZE_MULT-1:0] K4 = SIZE_MULT'(C4);
    localparam logic signed [SIZE_MULT-1:0] K5 = SIZE_MULT'(C5);
    localparam logic signed [SIZE_MULT-1:0] K6 = SIZE_MULT'(C6);
    localparam logic signed [SIZE_MULT-1:0] K7 = SIZE_MULT'(C7);
    localparam logic signed [SIZE_MULT-1:0] PROD_MASK =
        ~((SIZE_MULT'(1) << APPROX_BITS) - SIZE_MULT'(1));

    logic                        w_advance;
    logic signed [SIZE_MULT-1:0] w_x  [8];
    logic signed [SIZE_MULT-1:0] w_pe [6];
    logic signed [SIZE_MULT-1:0] w_po [4][4];

    logic                        r_v1;
    logic                        r_ap1;
    logic signed [SIZE_MULT-1:0] r_pe [6];
    logic signed [SIZE_MULT-1:0] r_po [4][4];

    logic signed [SIZE_MULT-1:0] w_me [6];
    logic signed [SIZE_MULT-1:0] w_mo [4][4];
    logic signed [SIZE_ACC-1:0]  w_e  [6];
    logic signed [SIZE_ACC-1:0]  w_o  [4][4];
    logic signed [SIZE_ACC-1:0]  w_even [4];
    logic signed [SIZE_ACC-1:0]  w_odd  [4];
    logic signed [SIZE_ACC-1:0]  w_acc  [8];

    logic                        r_v2;
    logic signed [SIZE_ACC-1:0]  r_acc [8];

    logic signed [SIZE-1:0]      w_pix [8];
    logic                        r_v3;
    logic [8*SIZE-1:0]           r_dout;

    assign w_advance = !r_v3 || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_v3;
    assign data_out  = r_dout;

    // Stage 1 operands: distinct coefficient*cosine products; signs are applied in the butterflies.
    // Even index: 0=X0*C4 1=X4*C4 2=X2*C2 3=X2*C6 4=X6*C2 5=X6*C6. Odd: [X1,X3,X5,X7][C1,C3,C5,C7].
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_x[k] = SIZE_MULT'($signed(data_in[k*SIZE_IN +: SIZE_IN]));
        end
        w_pe[0] = w_x[0] * K4;
        w_pe[1] = w_x[4] * K4;
        w_pe[2] = w_x[2] * K2;
        w_pe[3] = w_x[2] * K6;
        w_pe[4] = w_x[6] * K2;
        w_pe[5] = w_x[6] * K6;
        for (int j = 0; j < 4; j++) begin
            w_po[j][0] = w_x[2*j+1] * K1;
            w_po[j][1] = w_x[2*j+1] * K3;
            w_po[j][2] = w_x[2*j+1] * K5;
            w_po[j][3] = w_x[2*j+1] * K7;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1  <= 1'b0;
            r_ap1 <= 1'b0;
            r_pe  <= '{default: '0};
            r_po  <= '{default: '{default: '0}};
        end else if (w_advance) begin
            r_v1  <= in_valid;
            r_ap1 <= approx_en;
            r_pe  <= w_pe;
            r_po  <= w_po;
        end
    end

    // Stage 2: approximate truncation per product, then full-precision even/odd butterflies.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_me[i] = r_ap1 ? (r_pe[i] & PROD_MASK) : r_pe[i];
            w_e[i]  = SIZE_ACC'(w_me[i]);
        end
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < 4; c++) begin
                w_mo[j][c] = r_ap1 ? (r_po[j][c] & PROD_MASK) : r_po[j][c];
                w_o[j][c]  = SIZE_ACC'(w_mo[j][c]);
            end
        end
        w_even[0] = w_e[0] + w_e[2] + w_e[1] + w_e[5];
        w_even[1] = w_e[0] + w_e[3] - w_e[1] - w_e[4];
        w_even[2] = w_e[0] - w_e[3] - w_e[1] + w_e[4];
        w_even[3] = w_e[0] - w_e[2] + w_e[1] - w_e[5];
        w_odd[0]  = w_o[0][0] + w_o[1][1] + w_o[2][2] + w_o[3][3];
        w_odd[1]  = w_o[0][1] - w_o[1][3] - w_o[2][0] - w_o[3][2];
        w_odd[2]  = w_o[0][2] - w_o[1][0] + w_o[2][3] + w_o[3][1];
        w_odd[3]  = w_o[0][3] - w_o[1][2] + w_o[2][1] - w_o[3][0];
        for (int n = 0; n < 4; n++) begin
            w_acc[n]     = w_even[n] + w_odd[n];
            w_acc[7 - n] = w_even[n] - w_odd[n];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v2  <= 1'b0;
            r_acc <= '{default: '0};
        end else if (w_advance) begin
            r_v2  <= r_v1;
            r_acc <= w_acc;
        end
    end

    // Stage 3: round and clamp each lane into the output register.
    for (genvar g = 0; g < 8; g++) begin : g_rs
        idct_round_sat #(
            .SIZE     (SIZE),
            .SIZE_ACC (SIZE_ACC)
        ) u_round_sat (
            .i_acc (r_acc[g]),
            .o_pix (w_pix[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v3   <= 1'b0;
            r_dout <= '0;
        end else if (w_advance) begin
            r_v3 <= r_v2;
            for (int g = 0; g < 8; g++) begin
                r_dout[g*SIZE +: SIZE] <= w_pix[g];
            end
        end
    end

endmodule

// File: tb/tb_idct_col.sv
// Self-checking bench for idct_col: directed corner columns plus randomized streams
// compared against a direct cosine-sum reference model.
module tb_idct_col;

    localparam int SZ  = 8;
    localparam int SZI = 11;
    localparam int AB  = 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [8*SZI-1:0] data_in;
    logic            approx_en;
    logic            out_valid;
    logic            out_ready;
    logic [8*SZ-1:0] data_out;

    int n_pass = 0;
    int n_chk  = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    idct_col #(
        .SIZE        (SZ),
        .APPROX_BITS (AB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .approx_en (approx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cosine value scaled by 64 for index m in 0..8 (m=0 only occurs for k=0, which uses C4).
    function automatic int cos64(input int m);
        case (m)
            1: cos64 = 63;
            2: cos64 = 59;
            3: cos64 = 53;
            4: cos64 = 45;
            5: cos64 = 36;
            6: cos64 = 24;
            7: cos64 = 12;
            8: cos64 = 0;
            default: cos64 = 45;
        endcase
    endfunction

    // Direct 8x8 cosine sum, per-product truncation, round-half-up by 128, clamp.
    function automatic logic [63:0] ref_col(input logic [8*SZI-1:0] din, input logic ap);
        logic [63:0] res;
        int s, x, m, sg, p, q;
        res = '0;
        for (int n = 0; n < 8; n++) begin
            s = 0;
            for (int k = 0; k < 8; k++) begin
                x  = $signed(din[k*SZI +: SZI]);
                m  = ((2*n + 1) * k) % 32;
                sg = 1;
                if (m > 16) m = 32 - m;
                if (m > 8) begin
                    m  = 16 - m;
                    sg = -1;
                end
                p = x * cos64(m);
                if (ap) p = p - (((p % (2**AB)) + (2**AB)) % (2**AB));
                s = s + sg * p;
            end
            q = (s + 64) >>> 7;
            if (q > 127)  q = 127;
            if (q < -128) q = -128;
            res[n*8 +: 8] = 8'(q);
        end
        return res;
    endfunction

    function automatic logic [8*SZI-1:0] mk_col(input int x0, input int x1);
        logic [8*SZI-1:0] c;
        c = '0;
        c[0 +: SZI]   = SZI'(x0);
        c[SZI +: SZI] = SZI'(x1);
        return c;
    endfunction

    function automatic logic [8*SZI-1:0] rand_col();
        logic [8*SZI-1:0] c;
        int v;
        for (int k = 0; k < 8; k++) begin
            case ($urandom % 4)
                0: v = int'($urandom_range(0, 2047));
                1: v = int'($urandom_range(0, 63)) - 32;
                2: v = ($urandom % 2) ? 1023 : -1024;
                default: v = int'($urandom_range(0, 511)) - 256;
            endcase
            c[k*SZI +: SZI] = SZI'(v);
        end
        return c;
    endfunction

    // Records every accepted column's expected result and every delivered output.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            got_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back(ref_col(data_in, approx_en));
            if (out_valid && out_ready) got_q.push_back(data_out);
        end
    end

    // Sends one column into an empty pipeline and returns its result and latency (-1 on timeout).
    task automatic run_one(input logic [8*SZI-1:0] din, input logic ap,
                           output logic [63:0] dout, output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = din;
        approx_en = ap;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        data_in   = '0;
        approx_en = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        dout = data_out;
        if (!out_valid) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_chk++; if (data_out !== 64'h0) $display("FAIL reset_data_out: got %h want 0", data_out); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_dc();
        logic [63:0] d;
        int lat;
        run_one(mk_col(64, 0), 1'b0, d, lat);
        n_chk++; if (lat != 3) $display("FAIL dc_latency: got %0d want 3", lat); else n_pass++;
        n_chk++; if (d !== {8{8'd23}}) $display("FAIL dc_value: got %h want %h", d, {8{8'd23}}); else n_pass++;
    endtask

    task automatic test_ac1();
        logic [63:0] d;
        int lat;
        run_one(mk_col(0, 64), 1'b0, d, lat);
        n_chk++; if (d[7:0] !== 8'd32) $display("FAIL ac1_x0: got %h want 20", d[7:0]); else n_pass++;
        n_chk++; if (d[63:56] !== 8'hE1) $display("FAIL ac1_x7: got %h want e1", d[63:56]); else n_pass++;
        n_chk++; if (d !== ref_col(mk_col(0, 64), 1'b0)) $display("FAIL ac1_all: got %h want %h", d, ref_col(mk_col(0, 64), 1'b0)); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [63:0] d;
        int lat;
        run_one(mk_col(1023, 0), 1'b0, d, lat);
        n_chk++; if (d !== {8{8'h7F}}) $display("FAIL sat_pos: got %h want %h", d, {8{8'h7F}}); else n_pass++;
        run_one(mk_col(-1024, 0), 1'b0, d, lat);
        n_chk++; if (d !== {8{8'h80}}) $display("FAIL sat_neg: got %h want %h", d, {8{8'h80}}); else n_pass++;
        run_one(mk_col(1023, -1024), 1'b0, d, lat);
        n_chk++; if (d[7:0] !== 8'h80) $display("FAIL sat_mixed_x0: got %h want 80", d[7:0]); else n_pass++;
        n_chk++; if (d[63:56] !== 8'h7F) $display("FAIL sat_mixed_x7: got %h want 7f", d[63:56]); else n_pass++;
        n_chk++; if (d !== ref_col(mk_col(1023, -1024), 1'b0)) $display("FAIL sat_mixed_all: got %h want %h", d, ref_col(mk_col(1023, -1024), 1'b0)); else n_pass++;
    endtask

    task automatic test_approx();
        logic [63:0] d;
        logic [8*SZI-1:0] c;
        int lat, t;
        run_one(mk_col(64, 0), 1'b1, d, lat);
        n_chk++; if (d !== {8{8'd23}}) $display("FAIL approx_64: got %h want %h", d, {8{8'd23}}); else n_pass++;
        run_one(mk_col(65, 0), 1'b1, d, lat);
        n_chk++; if (d !== {8{8'd23}}) $display("FAIL approx_65: got %h want %h", d, {8{8'd23}}); else n_pass++;
        run_one(mk_col(65, 0), 1'b0, d, lat);
        n_chk++; if (d !== {8{8'd23}}) $display("FAIL exact_65: got %h want %h", d, {8{8'd23}}); else n_pass++;
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            c = rand_col();
            in_valid  = 1'b1;
            data_in   = c;
            approx_en = i[0];
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        approx_en = 1'b0;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        n_chk++; if (got_q.size() != 20 || exp_q.size() != 20) $display("FAIL approx_count: got %0d/%0d want 20", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL approx_col%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [8*SZI-1:0] cols[6];
        logic [63:0] held;
        int sent, cyc, stalls, t;
        logic acc;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 6; i++) cols[i] = rand_col();
        sent = 0; cyc = 0; stalls = 0; held = '0;
        while (sent < 6 && cyc < 100) begin
            out_ready = !(cyc >= 4 && cyc < 8);
            in_valid  = 1'b1;
            data_in   = cols[sent];
            approx_en = 1'b0;
            @(negedge clk);
            if (out_valid && !out_ready) begin
                n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, in_ready); else n_pass++;
                if (stalls > 0) begin
                    n_chk++; if (data_out !== held) $display("FAIL bp_hold cyc%0d: got %h want %h", cyc, data_out, held); else n_pass++;
                end
                held = data_out;
                stalls++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_chk++; if (stalls != 4) $display("FAIL bp_stall_cycles: got %0d want 4", stalls); else n_pass++;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        n_chk++; if (got_q.size() != 6 || exp_q.size() != 6) $display("FAIL bp_count: got %0d/%0d want 6", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_chk++; if (got_q[i] !== ref_col(cols[i], 1'b0)) $display("FAIL bp_col%0d: got %h want %h", i, got_q[i], ref_col(cols[i], 1'b0)); else n_pass++;
        end
    endtask

    task automatic test_random();
        int t;
        exp_q.delete();
        got_q.delete();
        for (int c = 0; c < 120; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            approx_en = 1'($urandom % 2);
            data_in   = rand_col();
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        n_chk++; if (got_q.size() != exp_q.size() || exp_q.size() == 0) $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_col%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [8*SZI-1:0] c;
        logic [63:0] d;
        int lat, seen;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            data_in   = rand_col();
            approx_en = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b want 1", out_valid); else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else n_pass++;
        n_chk++; if (data_out !== 64'h0) $display("FAIL rstmid_data_out: got %h want 0", data_out); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_chk++; if (seen != 0 || got_q.size() != 0) $display("FAIL rstmid_stale: got %0d outputs want 0", seen + got_q.size()); else n_pass++;
        c = rand_col();
        run_one(c, 1'b0, d, lat);
        n_chk++; if (lat != 3) $display("FAIL rstmid_latency: got %0d want 3", lat); else n_pass++;
        n_chk++; if (d !== ref_col(c, 1'b0)) $display("FAIL rstmid_value: got %h want %h", d, ref_col(c, 1'b0)); else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        approx_en = 1'b0;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_dc();
        test_ac1();
        test_saturation();
        test_approx();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
